// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-requester priority / round-robin arbiter.
// Holds the FSM state enum and the rotation helper used by the priority picker.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Rotate right by sh: result[i] = v[(i + sh) mod N_REQ].
  function automatic logic [N_REQ-1:0] rotr8(input logic [N_REQ-1:0] v,
                                             input logic [ID_W-1:0]  sh);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v};
    return dbl[sh +: N_REQ];
  endfunction

endpackage

// File: rtl/prio_pick8.sv
// Combinational 8-bit priority pick with rotation.
// The candidate vector is rotated by rot, the highest set bit wins, and the result is un-rotated.
module prio_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [ID_W-1:0]  rot,
  output logic [N_REQ-1:0] win,
  output logic [ID_W-1:0]  win_id,
  output logic             valid
);

  logic [N_REQ-1:0] rotated;
  logic [ID_W-1:0]  rot_id;
  logic             found;

  always_comb begin
    rotated = rotr8(cand, rot);
    rot_id  = '0;
    found   = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (!found && rotated[i]) begin
        rot_id = i[ID_W-1:0];
        found  = 1'b1;
      end
    end
  end

  // Rotated position 7 maps back to index rot-1, so the rotation base ends up lowest priority.
  assign win_id = rot_id + rot;
  assign valid  = found;
  assign win    = found ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_id) : '0;

endmodule

// File: rtl/prio_arbiter8.sv
// Eight-requester arbiter with fixed-priority or round-robin selection and an optional hold limit.
// Grant, index and busy are all registered; there is no path from req to the outputs.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ARB_IDLE  | no owner; any request is granted on the next edge
//   ARB_GRANT | gnt/gnt_id hold the owner; release or timeout re-arbitrates
module prio_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy
);

  localparam int                HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit                LIMITED  = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   last, last_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [N_REQ-1:0]  gnt_q, gnt_nxt;
  logic [ID_W-1:0]   id_q, id_nxt;
  logic              busy_q, busy_nxt;

  logic              owner_req;
  logic              at_limit;
  logic              timeout;
  logic [N_REQ-1:0]  cand;
  logic [ID_W-1:0]   rot;
  logic [N_REQ-1:0]  win;
  logic [ID_W-1:0]   win_id;
  logic              win_valid;

  assign owner_req = req[id_q];
  assign at_limit  = LIMITED && (hold_cnt == HOLD_MAX);
  assign timeout   = (state == ARB_GRANT) && owner_req && at_limit;

  // On release the owner's bit is already low, so only a timeout needs masking.
  assign cand = timeout ? (req & ~gnt_q) : req;
  assign rot  = mode ? last : '0;

  prio_pick8 u_pick (
    .cand   (cand),
    .rot    (rot),
    .win    (win),
    .win_id (win_id),
    .valid  (win_valid)
  );

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt_q;
    id_nxt       = id_q;
    busy_nxt     = busy_q;

    case (state)
      ARB_IDLE: begin
        if (win_valid) begin
          state_nxt    = ARB_GRANT;
          gnt_nxt      = win;
          id_nxt       = win_id;
          busy_nxt     = 1'b1;
          last_nxt     = win_id;
          hold_cnt_nxt = HOLD_ONE;
        end
      end

      ARB_GRANT: begin
        if (!owner_req) begin
          if (win_valid) begin
            gnt_nxt      = win;
            id_nxt       = win_id;
            last_nxt     = win_id;
            hold_cnt_nxt = HOLD_ONE;
          end else begin
            state_nxt    = ARB_IDLE;
            gnt_nxt      = '0;
            id_nxt       = '0;
            busy_nxt     = 1'b0;
            hold_cnt_nxt = '0;
          end
        end else if (at_limit) begin
          if (win_valid) begin
            gnt_nxt  = win;
            id_nxt   = win_id;
            last_nxt = win_id;
          end
          hold_cnt_nxt = HOLD_ONE;
        end else if (LIMITED || (hold_cnt != {HOLD_W{1'b1}})) begin
          hold_cnt_nxt = hold_cnt + HOLD_ONE;
        end
      end

      default: begin
        state_nxt    = ARB_IDLE;
        gnt_nxt      = '0;
        id_nxt       = '0;
        busy_nxt     = 1'b0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      last     <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      id_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_cnt_nxt;
      gnt_q    <= gnt_nxt;
      id_q     <= id_nxt;
      busy_q   <= busy_nxt;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_prio_arbiter8.sv
// Self-checking bench for prio_arbiter8 (MAX_HOLD=4): directed scenarios with literal
// expectations plus a randomized run compared every cycle against a behavioural model.
module tb_prio_arbiter8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  prio_arbiter8 #(.MAX_HOLD(MAXH)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Model state: owner index (-1 when nobody holds the resource), last winner, hold count.
  int         m_owner = -1;
  int         m_last  = 0;
  int         m_cnt   = 0;
  logic [7:0] edge_req = 8'h00;

  // Walk the priority order explicitly: fixed is 7..0, round-robin is last-1, last-2, ..., last.
  function automatic int pick(input logic [7:0] c, input logic m, input int lst);
    for (int k = 1; k <= 8; k++) begin
      if (m ? c[(lst - k + 16) % 8] : c[8 - k])
        return m ? (lst - k + 16) % 8 : 8 - k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    edge_req = req;
    if (rst) begin
      m_owner = -1;
      m_last  = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      w = pick(req, mode, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_cnt = 1;
      end
    end else if (!req[m_owner]) begin
      w = pick(req, mode, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_cnt = 1;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end else if (m_cnt == MAXH) begin
      w = pick(req & ~(8'h01 << m_owner), mode, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w;
      end
      m_cnt = 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    logic [7:0] eg;
    logic [2:0] eid;
    if (chk_en) begin
      eg  = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      eid = (m_owner >= 0) ? m_owner[2:0] : 3'd0;
      checks++;
      if (gnt !== eg) begin
        errors++;
        $display("FAIL model_gnt t=%0t got %h want %h", $time, gnt, eg);
      end
      checks++;
      if (gnt_id !== eid || busy !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL model_id_busy t=%0t got id %0d busy %0b want id %0d busy %0b",
                 $time, gnt_id, busy, eid, (m_owner >= 0));
      end
      checks++;
      if ($countones(gnt) > 1 || (gnt & ~edge_req) != 8'h00 ||
          (busy ? (gnt !== (8'h01 << gnt_id)) : (gnt !== 8'h00))) begin
        errors++;
        $display("FAIL legality t=%0t got gnt %h id %0d busy %0b req %h",
                 $time, gnt, gnt_id, busy, edge_req);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int ord [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int seen [8];

  initial begin
    // reset then idle
    rst = 1'b1; req = 8'h00; mode = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_gnt", gnt, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_id", gnt_id, 0);

    // fixed priority and bubble-free handover
    req = 8'h2C;
    step();
    check("fix_gnt", gnt, 8'h20);
    check("fix_id", gnt_id, 5);
    req = 8'h0C;
    step();
    check("fix_regnt", gnt, 8'h08);
    check("fix_reid", gnt_id, 3);
    check("fix_busy", busy, 1);
    req = 8'h00;
    step();
    check("fix_idle", gnt, 8'h00);

    // round-robin fairness, each owner releases after one cycle
    do_reset();
    mode = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 8; i++) seen[i] = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      check("rr_order", gnt_id, ord[k]);
      check("rr_gnt", gnt, 8'h01 << ord[k]);
      if (k < 8) seen[gnt_id]++;
      req = 8'hFF & ~(8'h01 << ord[k]);
    end
    for (int i = 0; i < 8; i++) check("rr_fair", seen[i], 1);

    // hold timeout with a competitor
    do_reset();
    mode = 1'b0;
    req = 8'h81;
    for (int c = 0; c < 4; c++) begin
      step();
      check("hold_owner", gnt, 8'h80);
    end
    step();
    check("hold_rotate", gnt, 8'h01);

    // hold timeout with no competitor
    do_reset();
    req = 8'h80;
    for (int c = 0; c < 4; c++) begin
      step();
      check("solo_owner", gnt, 8'h80);
    end
    step();
    check("solo_keep", gnt, 8'h80);
    check("solo_restart", dut.hold_cnt, 1);
    step();
    check("solo_cnt2", dut.hold_cnt, 2);

    // reset mid-grant restarts round-robin base
    do_reset();
    req = 8'h10;
    step();
    check("mid_gnt", gnt, 8'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_gnt", gnt, 8'h00);
    check("mid_rst_busy", busy, 0);
    mode = 1'b1;
    req = 8'h11;
    step();
    check("mid_rr_gnt", gnt, 8'h10);

    // randomized run against the model
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0)
        req = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      else if ($urandom_range(0, 4) == 0)
        req = req & ~gnt;
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
